// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte-lane writes,
// selectable read latency / write mode and a hardware clear engine
// that zeroes the whole array one word per cycle.
module sp_ram_param #(
    parameter int DATA_W     = 18,
    parameter int ADDR_W     = 7,
    parameter int BYTE_W     = 9,
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     oce,
    input  logic                     wre,
    input  logic [ADDR_W-1:0]        ad,
    input  logic [DATA_W-1:0]        din,
    input  logic [DATA_W/BYTE_W-1:0] be,
    input  logic                     clr_req,
    output logic [DATA_W-1:0]        dout,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NBE   = DATA_W / BYTE_W;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // Reject configurations the lane logic and write-mode mux cannot express.
    generate
        if ((DATA_W % BYTE_W) != 0 || WRITE_MODE > 2) begin : g_bad_params
            $error("sp_ram_param: DATA_W must be a multiple of BYTE_W and WRITE_MODE must be 0..2");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;

    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic              w_access;
    logic              w_write;

    // User accesses are only honoured out of reset and while the sweep is idle.
    assign w_old    = r_mem[ad];
    assign w_access = !reset && (r_state == ST_IDLE) && ce;
    assign w_write  = w_access && wre;

    // Merge enabled byte lanes of din over the currently stored word.
    always_comb begin
        // NOTE: default assignment first so every path drives w_merged and no latch is inferred.
        w_merged = w_old;
        for (int i = 0; i < NBE; i++) begin
            if (be[i]) begin
                w_merged[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Clear-engine FSM: sweep counter and registered busy flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (reset) begin
            r_state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= (CLR_ON_RST != 0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: sweep zeroes mem[cnt], otherwise the merged user word.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch so it maps onto block RAM; the clear engine zeroes it instead.
        if (!reset && r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_write) begin
            r_mem[ad] <= w_merged;
        end
    end

    // Stage-1 data register: read data, or per WRITE_MODE on a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
        end else if (w_access) begin
            if (!wre) begin
                r_s1 <= w_old;
            end else if (WRITE_MODE == 1) begin
                r_s1 <= w_merged;
            end else if (WRITE_MODE == 2) begin
                r_s1 <= w_old;
            end
        end
    end

    // Stage-2 output register: advances on oce regardless of sweep or ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2 <= '0;
        end else if (oce) begin
            r_s2 <= r_s1;
        end
    end

    assign dout = (READ_MODE == 1) ? r_s2 : r_s1;
    assign busy = r_busy;

endmodule

// File: tb/tb_sp_ram_param.sv
// Self-checking bench for sp_ram_param: three instances (bypass/normal,
// pipeline/write-through, bypass/read-before-write) share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_sp_ram_param;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;
    localparam int NBE    = 2;
    localparam int BYTE_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              ce;
    logic              oce;
    logic              wre;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] din;
    logic [NBE-1:0]    be;
    logic              clr_req;
    logic [DATA_W-1:0] dout0, dout1, dout2;
    logic              busy0, busy1, busy2;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: array contents, remaining sweep cycles, and the
    // word each write mode presents after an access (index = WRITE_MODE).
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] m_s1  [3];
    logic [DATA_W-1:0] m_s2;
    int                m_left;

    always #5 clk = ~clk;

    sp_ram_param #(.READ_MODE(0), .WRITE_MODE(0)) u_m0 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
        .din(din), .be(be), .clr_req(clr_req), .dout(dout0), .busy(busy0));

    sp_ram_param #(.READ_MODE(1), .WRITE_MODE(1)) u_m1 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
        .din(din), .be(be), .clr_req(clr_req), .dout(dout1), .busy(busy1));

    sp_ram_param #(.READ_MODE(0), .WRITE_MODE(2)) u_m2 (
        .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
        .din(din), .be(be), .clr_req(clr_req), .dout(dout2), .busy(busy2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_update();
        logic [DATA_W-1:0] old_w;
        logic [DATA_W-1:0] new_w;
        logic [DATA_W-1:0] s2_next;
        if (reset) begin
            m_s1[0] = '0; m_s1[1] = '0; m_s1[2] = '0;
            m_s2    = '0;
            m_left  = DEPTH;
        end else begin
            s2_next = oce ? m_s1[1] : m_s2;
            if (m_left > 0) begin
                m_mem[DEPTH - m_left] = '0;
                m_left--;
            end else begin
                if (clr_req) m_left = DEPTH;
                if (ce) begin
                    old_w = m_mem[ad];
                    if (!wre) begin
                        m_s1[0] = old_w; m_s1[1] = old_w; m_s1[2] = old_w;
                    end else begin
                        new_w = old_w;
                        for (int i = 0; i < NBE; i++)
                            if (be[i]) new_w[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
                        m_mem[ad] = new_w;
                        m_s1[1]   = new_w;
                        m_s1[2]   = old_w;
                    end
                end
            end
            m_s2 = s2_next;
        end
    endtask

    // One clock edge, then compare every instance against the model.
    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        check("busy_m0", 32'(busy0), 32'(m_left > 0));
        check("busy_m1", 32'(busy1), 32'(m_left > 0));
        check("busy_m2", 32'(busy2), 32'(m_left > 0));
        check("dout_m0", 32'(dout0), 32'(m_s1[0]));
        check("dout_m1", 32'(dout1), 32'(m_s2));
        check("dout_m2", 32'(dout2), 32'(m_s1[2]));
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [NBE-1:0] b, input logic o);
        ce = 1'b1; wre = 1'b1; ad = a; din = d; be = b; oce = o; clr_req = 1'b0;
        step();
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic o);
        ce = 1'b1; wre = 1'b0; ad = a; din = '0; be = '0; oce = o; clr_req = 1'b0;
        step();
    endtask

    task automatic idle(input logic o);
        ce = 1'b0; wre = 1'b0; oce = o; clr_req = 1'b0;
        step();
    endtask

    task automatic pulse_clr();
        ce = 1'b0; wre = 1'b0; oce = 1'b1; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_s1[0] = '0; m_s1[1] = '0; m_s1[2] = '0;
        m_s2 = '0; m_left = 0;
        reset = 1'b1; ce = 1'b0; oce = 1'b0; wre = 1'b0;
        ad = '0; din = '0; be = '0; clr_req = 1'b0;

        // Reset and automatic clear sweep.
        repeat (3) step();
        check("rst_dout0", 32'(dout0), 32'h0);
        check("rst_dout1", 32'(dout1), 32'h0);
        reset = 1'b0;
        oce   = 1'b1;
        cnt = 0;
        while (busy0 && cnt < 300) begin
            cnt++;
            step();
        end
        check("rst_busy_len", 32'(cnt), 32'd128);
        for (int a = 0; a < DEPTH; a++) begin
            rd(ADDR_W'(a), 1'b1);
            check("rst_zero", 32'(dout0), 32'h0);
        end

        // Read latency in both read modes, oce hold.
        wr(7'd5, 18'h2A5A5, 2'b11, 1'b1);
        rd(7'd6, 1'b1);
        idle(1'b1);
        rd(7'd5, 1'b1);
        check("lat_bypass", 32'(dout0), 32'h2A5A5);
        check("lat_pipe_early", 32'(dout1), 32'h0);
        idle(1'b1);
        check("lat_pipe", 32'(dout1), 32'h2A5A5);
        rd(7'd6, 1'b0);
        check("oce_hold_a", 32'(dout1), 32'h2A5A5);
        idle(1'b0);
        check("oce_hold_b", 32'(dout1), 32'h2A5A5);
        idle(1'b1);
        check("oce_resume", 32'(dout1), 32'h0);

        // Write modes.
        wr(7'd3, 18'h00111, 2'b11, 1'b1);
        rd(7'd5, 1'b1);
        wr(7'd3, 18'h3FFFF, 2'b11, 1'b1);
        check("wm0_hold", 32'(dout0), 32'h2A5A5);
        check("wm2_rbw", 32'(dout2), 32'h00111);
        idle(1'b1);
        check("wm1_thru", 32'(dout1), 32'h3FFFF);

        // Byte lanes and be=0.
        wr(7'd9, 18'h3FFFF, 2'b01, 1'b1);
        rd(7'd9, 1'b1);
        check("lane_lo", 32'(dout0), 32'h001FF);
        wr(7'd9, 18'h3FFFF, 2'b00, 1'b1);
        check("be0_rbw", 32'(dout2), 32'h001FF);
        rd(7'd9, 1'b1);
        check("be0_keep", 32'(dout0), 32'h001FF);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            ce = 1'($urandom); wre = 1'($urandom); oce = 1'($urandom);
            ad = ADDR_W'($urandom); din = DATA_W'($urandom); be = NBE'($urandom);
            clr_req = 1'b0;
            step();
        end

        // Clear mid-run: writes and a second clr_req while busy are dropped.
        for (int a = 0; a < DEPTH; a++) wr(ADDR_W'(a), DATA_W'($urandom) | 18'h1, 2'b11, 1'b1);
        pulse_clr();
        cnt = 0;
        while (busy0 && cnt < 300) begin
            ce = 1'b1; wre = 1'b1; oce = 1'b1;
            ad = ADDR_W'($urandom); din = DATA_W'($urandom); be = 2'b11;
            clr_req = (cnt == 30);
            cnt++;
            step();
        end
        clr_req = 1'b0;
        check("clr_busy_len", 32'(cnt), 32'd128);
        for (int a = 0; a < DEPTH; a++) begin
            rd(ADDR_W'(a), 1'b1);
            check("clr_zero", 32'(dout0), 32'h0);
        end

        // Reset 40 cycles into a sweep restarts it from address 0.
        for (int a = 0; a < DEPTH; a++) wr(ADDR_W'(a), DATA_W'($urandom) | 18'h2, 2'b11, 1'b1);
        pulse_clr();
        repeat (40) idle(1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 300) begin
            cnt++;
            idle(1'b1);
        end
        check("rst_mid_busy_len", 32'(cnt), 32'd128);
        for (int a = 0; a < DEPTH; a++) begin
            rd(ADDR_W'(a), 1'b1);
            check("rst_mid_zero", 32'(dout0), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
